lcd_mmio_ctrl: RTL and testbench

- Memory-mapped responder for the character-LCD port; sits on the LSU output-peripheral address window.
- CPU stores push command/data bytes into a FIFO; an FSM replays each byte onto the LCD pins with programmable setup/enable/hold/execute timing.
- Removes software bit-banging of EN/RS. Loads return status so firmware can poll for space or idle.

---
 rtl/lcd_mmio_ctrl_if.sv | 19 +
 rtl/lcd_mmio_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_lcd_mmio_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_mmio_ctrl_if.sv
// LSU-side bus for the character-LCD MMIO responder.
// The LSU drives the select/store/address signals. The peripheral returns combinational read data.
interface lcd_mmio_ctrl_if;
    logic        cs_i;
    logic        wren_i;
    logic [3:0]  addr_i;
    logic [31:0] st_data_i;
    logic [31:0] ld_data_o;

    modport master (
        output cs_i, wren_i, addr_i, st_data_i,
        input  ld_data_o
    );

    modport slave (
        input  cs_i, wren_i, addr_i, st_data_i,
        output ld_data_o
    );
endinterface

// File: rtl/lcd_mmio_ctrl.sv
// Character-LCD MMIO controller.
// CPU stores queue RS/DB bytes into a FIFO. A timing FSM replays each byte onto the
// LCD pins as a setup / enable / hold / execute-wait sequence.
module lcd_mmio_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 4,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 10,
    parameter int LONG_EXEC_CYC = 100
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    lcd_mmio_ctrl_if.slave       bus,
    output logic [31:0]          io_lcd_o,
    output logic                 irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] EN_LD    = 16'(EN_CYC - 1);
    localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] EXEC_LD  = 16'(EXEC_CYC - 1);
    localparam logic [15:0] LONG_LD  = 16'(LONG_EXEC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    // ---------------- register decode ----------------
    logic       wr_act;
    logic [1:0] sel;
    logic       push_req, ctrl_wr, flush, ovf_clr;
    logic       push_ok, push_rej, pop;
    logic       full, empty;

    // FIFO storage and pointers; entry = {RS, DB}
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [8:0]    head;

    // control / status
    logic ctrl_on_q, ctrl_ie_q, ovf_q;

    // FSM
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        en_q, en_d;
    logic        rs_q, rs_d;
    logic [7:0]  db_q, db_d;
    logic        long_cmd;

    // Only word-aligned addresses and the low data byte matter.
    logic unused_bits;
    assign unused_bits = ^{bus.addr_i[1:0], bus.st_data_i[31:8]};

    assign wr_act   = bus.cs_i & bus.wren_i;
    assign sel      = bus.addr_i[3:2];
    assign push_req = wr_act & (sel == 2'd0 || sel == 2'd1);
    assign ctrl_wr  = wr_act & (sel == 2'd3);
    assign flush    = ctrl_wr & bus.st_data_i[2];
    assign ovf_clr  = ctrl_wr & bus.st_data_i[3];

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // Space is judged on the pre-edge count, so a same-cycle pop never makes room.
    assign push_ok  = push_req & ~full & ~flush;
    assign push_rej = push_req & full & ~flush;
    assign pop      = (state_q == S_IDLE) & ~empty;
    assign head     = mem_q[rd_ptr_q];

    // Clear and return-home commands need the long execute wait.
    assign long_cmd = ~rs_q & (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03);

    // FIFO storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {sel[0], bus.st_data_i[7:0]};
    end

    // FIFO pointers and occupancy; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // CTRL bits, sticky overflow and the idle interrupt.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_on_q <= 1'b0;
            ctrl_ie_q <= 1'b0;
            ovf_q     <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_on_q <= bus.st_data_i[0];
                ctrl_ie_q <= bus.st_data_i[1];
            end
            if (push_rej)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
            irq_o <= empty & (state_q == S_IDLE) & ctrl_ie_q;
        end
    end

    // FSM state, down-counter and registered pin drivers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
        end
    end

    // Next-state: each phase counts down to zero, then loads the next phase length.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 16'd1;
        en_d    = en_q;
        rs_d    = rs_q;
        db_d    = db_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                en_d  = 1'b0;
                if (!empty) begin
                    rs_d    = head[8];
                    db_d    = head[7:0];
                    cnt_d   = SETUP_LD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b1;
                    cnt_d   = EN_LD;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = long_cmd ? LONG_LD : EXEC_LD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0)
                    state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin word: every bit comes straight from a flop, RW is tied low.
    always_comb begin
        io_lcd_o     = '0;
        io_lcd_o[31] = ctrl_on_q;
        io_lcd_o[10] = en_q;
        io_lcd_o[9]  = rs_q;
        io_lcd_o[7:0] = db_q;
    end

    // Combinational read mux; the LSU qualifies it with its own select.
    always_comb begin
        bus.ld_data_o = '0;
        unique case (sel)
            2'd2: begin
                bus.ld_data_o[0]    = (state_q != S_IDLE) | ~empty;
                bus.ld_data_o[1]    = full;
                bus.ld_data_o[2]    = empty;
                bus.ld_data_o[3]    = ovf_q;
                bus.ld_data_o[15:8] = 8'(count_q);
            end
            2'd3: begin
                bus.ld_data_o[0] = ctrl_on_q;
                bus.ld_data_o[1] = ctrl_ie_q;
            end
            default: bus.ld_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_lcd_mmio_ctrl.sv
// Directed bench for lcd_mmio_ctrl. Expected {RS,DB} bytes are queued at each store,
// and a pin monitor pops them on every EN rising edge.
module tb_lcd_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_lcd;
    logic        irq;

    lcd_mmio_ctrl_if bus();

    lcd_mmio_ctrl dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus),
        .io_lcd_o (io_lcd),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] exp_q[$];
    int rise_cnt = 0, last_rise = 0, prev_rise = 0, fall_cyc = 0;
    bit skip_width = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Edge counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pin monitor: scoreboard pop on EN rise, pulse-width check on EN fall
    initial begin
        logic en_prev;
        logic [8:0] e;
        en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (io_lcd[10] === 1'b1 && en_prev === 1'b0) begin
                rise_cnt++;
                prev_rise = last_rise;
                last_rise = cyc;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pulse", 32'(rise_cnt), 32'(rise_cnt - 1));
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_item", 32'({io_lcd[9], io_lcd[7:0]}), 32'(e));
                end
            end
            if (io_lcd[10] === 1'b0 && en_prev === 1'b1) begin
                fall_cyc = cyc;
                if (!skip_width) chk("en_width", 32'(cyc - last_rise), 32'd4);
            end
            en_prev = io_lcd[10];
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs_i = 1'b1; bus.wren_i = 1'b1; bus.addr_i = a; bus.st_data_i = d;
        @(posedge clk); #1;
        bus.cs_i = 1'b0; bus.wren_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.addr_i = a;
        #1 v = bus.ld_data_o;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_en_high(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (io_lcd[10] === 1'b1) break;
            step(1);
        end
        chk("en_rise_timeout", 32'(io_lcd[10]), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        logic [31:0] s;
        s = '1;
        for (int k = 0; k < bound; k++) begin
            rd(4'h8, s);
            if (s[0] === 1'b0) break;
        end
        chk("idle_timeout", 32'(s[0]), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int t0, r0;

        rst = 1'b1;
        bus.cs_i = 1'b0; bus.wren_i = 1'b0; bus.addr_i = '0; bus.st_data_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        rd(4'h8, v); chk("rst_status", v, 32'h0000_0004);
        chk("rst_pins", io_lcd, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd(4'hC, v); chk("rst_ctrl", v, 32'h0);

        // Single DATA byte timing
        wr(4'hC, 32'h3);
        rd(4'hC, v); chk("ctrl_readback", v, 32'h3);
        wr(4'h4, 32'h41); t0 = cyc; exp_q.push_back(9'h141);
        step(1); chk("t1_pins", io_lcd, 32'h8000_0241);
        step(18);
        rd(4'h8, v); chk("t19_status", v, 32'h0000_0004);
        chk("t19_irq", 32'(irq), 32'd0);
        step(1); chk("t20_irq", 32'(irq), 32'd1);
        chk("en_rise_cyc", 32'(last_rise - t0), 32'd3);
        chk("en_fall_cyc", 32'(fall_cyc - t0), 32'd7);
        chk("pins_retained", io_lcd, 32'h8000_0241);
        rd(4'h0, v); chk("cmd_reads_zero", v, 32'h0);

        // Long command followed by data
        r0 = rise_cnt;
        wr(4'h0, 32'h01); exp_q.push_back(9'h001);
        wr(4'h4, 32'h42); exp_q.push_back(9'h142);
        wait_idle(400);
        chk("long_pulses", 32'(rise_cnt - r0), 32'd2);
        chk("long_spacing", 32'(last_rise - prev_rise), 32'd109);

        // Overflow: 10 back-to-back stores, 9 accepted
        r0 = rise_cnt;
        for (int i = 0; i < 10; i++) begin
            wr(4'h4, 32'(8'h60 + i));
            if (i < 9) exp_q.push_back({1'b1, 8'(8'h60 + i)});
        end
        rd(4'h8, v); chk("ovf_status", v, 32'h0000_080B);
        wr(4'hC, 32'hB);
        rd(4'h8, v); chk("ovf_cleared", v, 32'h0000_0803);
        wait_idle(400);
        chk("ovf_pulses", 32'(rise_cnt - r0), 32'd9);
        chk("ovf_sb_drained", 32'(exp_q.size()), 32'd0);

        // Flush during PULSE of first byte
        r0 = rise_cnt;
        for (int i = 0; i < 4; i++) wr(4'h4, 32'(8'h70 + i));
        exp_q.push_back(9'h170);
        wait_en_high(20);
        wr(4'hC, 32'h7);
        wait_idle(200);
        chk("flush_pulses", 32'(rise_cnt - r0), 32'd1);
        rd(4'h8, v); chk("flush_status", v, 32'h0000_0004);
        step(40);
        chk("flush_no_more", 32'(rise_cnt - r0), 32'd1);

        // Reset during PULSE, then a normal transfer
        wr(4'h4, 32'h33); exp_q.push_back(9'h133);
        wait_en_high(20);
        skip_width = 1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pins", io_lcd, 32'h0);
        chk("midrst_irq", 32'(irq), 32'd0);
        rd(4'h8, v); chk("midrst_status", v, 32'h0000_0004);
        rd(4'hC, v); chk("midrst_ctrl", v, 32'h0);
        rst = 1'b0;
        step(2);
        skip_width = 0;
        r0 = rise_cnt;
        wr(4'h4, 32'h55); exp_q.push_back(9'h155);
        wait_idle(100);
        chk("post_rst_pulse", 32'(rise_cnt - r0), 32'd1);
        chk("post_rst_pins", io_lcd, 32'h0000_0255);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
